// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB command master.
package apb_pkg;

    // Transfer phases of one APB access plus the response hand-off.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam logic APB_READ  = 1'b0;
    localparam logic APB_WRITE = 1'b1;
    localparam logic APB_OKAY  = 1'b0;
    localparam logic APB_ERROR = 1'b1;

    // Number of byte-offset address bits that are zero on an aligned bus word.
    function automatic int addr_lsb(input int dw);
        return $clog2(dw / 8);
    endfunction

    // Counter width able to hold 0 .. timeout-1 (at least one bit).
    function automatic int cnt_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS cycles spent waiting for PREADY and flags the last allowed one.
module apb_timeout_cnt
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = cnt_width(TIMEOUT);

    logic [CW-1:0] cnt;

    // Wait-cycle counter: restarts before each ACCESS phase, advances on each stalled cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Expiry is flagged during the TIMEOUT-th stalled cycle so the FSM leaves on that edge.
    // A TIMEOUT of zero never expires.
    always_comb begin
        expired = 1'b0;
        if (TIMEOUT != 0) begin
            expired = enable && (cnt == CW'(TIMEOUT - 1));
        end
    end

endmodule

// File: rtl/apb_cmd_master.sv
// Turns a valid/ready command stream into single APB transfers and returns
// one response per command, with an optional PREADY timeout.
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    // command channel
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [DW-1:0]   cmd_wdata,
    input  logic [DW/8-1:0] cmd_strb,
    // response channel
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,
    output logic            rsp_timeout,
    // APB master
    output logic            PSEL,
    output logic            PENABLE,
    output logic [AW-1:0]   PADDR,
    output logic            PWRITE,
    output logic [DW-1:0]   PWDATA,
    output logic [DW/8-1:0] PSTRB,
    input  logic [DW-1:0]   PRDATA,
    input  logic            PREADY,
    input  logic            PSLVERR
);

    // Clears the byte-offset bits so PADDR is always bus-word aligned.
    localparam logic [AW-1:0] ADDR_MASK = ~AW'((1 << addr_lsb(DW)) - 1);

    apb_state_e state;
    logic       tmo_clear;
    logic       tmo_enable;
    logic       tmo_expired;

    // NOTE: cmd_ready is gated by rst directly so no command can be taken
    // during the reset cycle itself, even though state is still registered.
    assign cmd_ready = (state == ST_IDLE) && !rst;

    // The wait counter restarts in SETUP and counts only stalled ACCESS cycles.
    assign tmo_clear  = (state == ST_SETUP);
    assign tmo_enable = (state == ST_ACCESS) && !PREADY;

    apb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    // Transfer FSM with all APB and response outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the address/data registers are cleared too, because they are
            // visible on the bus and must read as zero straight out of reset.
            state       <= ST_IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees the
            // pre-edge values of state and the bus registers.
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state  <= ST_SETUP;
                        PSEL   <= 1'b1;
                        PADDR  <= cmd_addr & ADDR_MASK;
                        PWRITE <= cmd_write;
                        PWDATA <= cmd_wdata;
                        PSTRB  <= (cmd_write == APB_WRITE) ? cmd_strb : '0;
                    end
                end

                ST_SETUP: begin
                    state   <= ST_ACCESS;
                    PENABLE <= 1'b1;
                end

                ST_ACCESS: begin
                    // A slave that answers on the final allowed cycle still wins over the timeout.
                    if (PREADY) begin
                        state       <= ST_RESP;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= (PWRITE == APB_WRITE) ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                    end else if (tmo_expired) begin
                        state       <= ST_RESP;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= APB_ERROR;
                        rsp_timeout <= 1'b1;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed corner cases plus random
// transactions, with expectations derived from transfer-level rules.
module tb_apb_cmd_master;

    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int TIMEOUT = 16;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_strb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          PSEL;
    logic          PENABLE;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [3:0]    PSTRB;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    int n_total = 0;
    int n_bad   = 0;

    apb_cmd_master #(
        .DW      (DW),
        .AW      (AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PADDR       (PADDR),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PSTRB       (PSTRB),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Random noise on slave inputs; the DUT must ignore it outside ACCESS.
    task automatic slave_noise();
        PREADY  = 1'($urandom_range(0, 1));
        PSLVERR = 1'($urandom_range(0, 1));
        PRDATA  = $urandom;
    endtask

    task automatic cmd_noise();
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom_range(0, 15));
    endtask

    // One full command: offered in the current (IDLE) cycle, slave answers in
    // ACCESS cycle index rdy_dly (0 = first), response held for rsp_wait cycles.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int rdy_dly, input logic slverr,
                           input logic [31:0] rdata, input int rsp_wait);
        logic [31:0] exp_paddr;
        logic [3:0]  exp_pstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_tmo;
        int          n_acc;

        // Transfer-level model of the expected outcome.
        exp_paddr = {addr[31:2], 2'b00};
        exp_pstrb = wr ? strb : 4'h0;
        exp_tmo   = (TIMEOUT != 0) && (rdy_dly >= TIMEOUT);
        n_acc     = exp_tmo ? TIMEOUT : rdy_dly + 1;
        exp_rdata = (exp_tmo || wr) ? 32'h0 : rdata;
        exp_err   = exp_tmo ? 1'b1 : slverr;

        // Accepting cycle
        check("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        rsp_ready = 1'b0;
        slave_noise();
        step();

        // SETUP cycle: command inputs scrambled to prove they were registered
        cmd_valid = 1'b0;
        cmd_noise();
        slave_noise();
        check("setup_psel", PSEL, 1'b1);
        check("setup_penable", PENABLE, 1'b0);
        check("setup_paddr", PADDR, exp_paddr);
        check("setup_pwrite", PWRITE, wr);
        check("setup_pstrb", PSTRB, exp_pstrb);
        if (wr) check("setup_pwdata", PWDATA, wdata);
        check("setup_cmd_ready", cmd_ready, 1'b0);
        step();

        // ACCESS cycles
        for (int k = 0; k < n_acc; k++) begin
            check("acc_psel", PSEL, 1'b1);
            check("acc_penable", PENABLE, 1'b1);
            check("acc_paddr", PADDR, exp_paddr);
            check("acc_pwrite", PWRITE, wr);
            check("acc_pstrb", PSTRB, exp_pstrb);
            if (wr) check("acc_pwdata", PWDATA, wdata);
            check("acc_rsp_valid", rsp_valid, 1'b0);
            PREADY  = (k == rdy_dly);
            PRDATA  = (k == rdy_dly) ? rdata : $urandom;
            PSLVERR = (k == rdy_dly) ? slverr : 1'($urandom_range(0, 1));
            step();
        end

        // RESP cycles: response must hold while rsp_ready is low
        slave_noise();
        for (int w = 0; w <= rsp_wait; w++) begin
            check("rsp_valid", rsp_valid, 1'b1);
            check("rsp_rdata", rsp_rdata, exp_rdata);
            check("rsp_err", rsp_err, exp_err);
            check("rsp_timeout", rsp_timeout, exp_tmo);
            check("rsp_psel", PSEL, 1'b0);
            check("rsp_penable", PENABLE, 1'b0);
            check("rsp_cmd_ready", cmd_ready, 1'b0);
            rsp_ready = (w == rsp_wait);
            cmd_valid = (w == rsp_wait) ? 1'b0 : 1'b1;
            cmd_noise();
            slave_noise();
            step();
        end
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("done_rsp_valid", rsp_valid, 1'b0);
        check("done_cmd_ready", cmd_ready, 1'b1);
    endtask

    // Reset pulse for one cycle either during ACCESS or while a response is pending.
    task automatic reset_mid(input bit in_resp);
        check("rm_cmd_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0204;
        cmd_strb  = 4'h0;
        PREADY    = 1'b0;
        rsp_ready = 1'b0;
        step();
        cmd_valid = 1'b0;
        step();
        check("rm_in_access", PENABLE, 1'b1);
        if (in_resp) begin
            PREADY = 1'b1;
            PRDATA = 32'hA5A5_5A5A;
            step();
            PREADY = 1'b0;
            check("rm_resp_pending", rsp_valid, 1'b1);
        end else begin
            PREADY = 1'b0;
            step();
        end
        rst = 1'b1;
        #1;
        check("rm_cmd_ready_in_rst", cmd_ready, 1'b0);
        step();
        rst = 1'b0;
        #1;
        check("rm_psel", PSEL, 1'b0);
        check("rm_penable", PENABLE, 1'b0);
        check("rm_rsp_valid", rsp_valid, 1'b0);
        check("rm_paddr", PADDR, 32'h0);
        check("rm_rsp_rdata", rsp_rdata, 32'h0);
        check("rm_cmd_ready", cmd_ready, 1'b1);
        step();
        check("rm_rsp_stays_low", rsp_valid, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_psel", PSEL, 1'b0);
        check("rst_penable", PENABLE, 1'b0);
        check("rst_paddr", PADDR, 32'h0);
        check("rst_pwdata", PWDATA, 32'h0);
        check("rst_pstrb", PSTRB, 4'h0);
        check("rst_pwrite", PWRITE, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_rsp_timeout", rsp_timeout, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_cmd_ready", cmd_ready, 1'b1);

        // Directed cases
        run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0, 0);          // minimum write, same-cycle rsp_ready
        run_txn(1'b0, 32'h0000_0104, 32'h0, 4'hF, 3, 1'b0, 32'h1234_5678, 1);          // delayed read
        run_txn(1'b0, 32'h0000_0020, 32'h0, 4'h0, 100, 1'b0, 32'hFFFF_FFFF, 0);        // timeout
        run_txn(1'b0, 32'h0000_0030, 32'h0, 4'h0, 0, 1'b1, 32'hCAFE_F00D, 0);          // slave error
        run_txn(1'b1, 32'h0000_0040, 32'h0BAD_F00D, 4'h5, 1, 1'b0, 32'h0, 5);          // long response hold
        run_txn(1'b1, 32'h0000_0050, 32'h1111_2222, 4'h3, TIMEOUT - 1, 1'b0, 32'h0, 0); // ready on last allowed cycle
        run_txn(1'b1, 32'h0000_0060, 32'h3333_4444, 4'hC, TIMEOUT, 1'b1, 32'h0, 0);    // first timing-out delay
        run_txn(1'b0, 32'h0000_0107, 32'h0, 4'hF, 2, 1'b0, 32'h7654_3210, 2);          // unaligned address read

        // Random traffic
        for (int i = 0; i < 30; i++) begin
            int dly;
            dly = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT, TIMEOUT + 8)
                                              : $urandom_range(0, TIMEOUT + 1);
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                    dly, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3));
        end

        // Reset during a transfer and during a pending response
        reset_mid(1'b0);
        reset_mid(1'b1);
        run_txn(1'b0, 32'h0000_0300, 32'h0, 4'h0, 1, 1'b0, 32'h0F0F_0F0F, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
